ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage with a prefetch queue, feeding the IF/ID pipeline register of the pipelined MIPS core. It generates sequential fetch addresses, issues them to the instruction memory over a request/response handshake with variable latency, and buffers returned words with their PCs. Branch and jump redirects flush the queue and discard any in-flight response. IF/ID stalls back-pressure it through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  32  byte address of request, word aligned
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response word valid
- imem_rdata  in  32  response instruction word
- redirect  in  1  branch/jump taken; flush and restart
- redirect_pc  in  32  new fetch address (bits [1:0] ignored, forced 0)
- out_valid  out  1  out_instr/out_pc valid to IF/ID
- out_instr  out  32  instruction word
- out_pc  out  32  fetch address of out_instr
- out_ready  in  1  IF/ID write enable; transfer when out_valid && out_ready

## Operation
- Registers: fetch_pc, queue (instr+pc per entry), count, one outstanding-request tracker (pend, pend_pc), FSM.
- FSM states: IDLE (no request outstanding), WAIT (one accepted request outstanding), DROP (outstanding response to be discarded).
- Request rule: imem_req = !redirect && state==IDLE && (count + 0) < DEPTH, counting the in-flight slot so a response always has space. Max one outstanding request.
- On imem_req && imem_ready: pend_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (32-bit wrap), IDLE→WAIT.
- WAIT with imem_rvalid: push {imem_rdata, pend_pc}; WAIT→IDLE (may issue new request next cycle).
- Pop when out_valid && out_ready; push and pop in the same cycle leave count unchanged.
- redirect (highest priority): count <= 0, fetch_pc <= {redirect_pc[31:2],2'b00}; WAIT→DROP, DROP stays DROP, IDLE stays IDLE. Same-cycle imem_rvalid is discarded.
- DROP with imem_rvalid: discard word, DROP→IDLE.
- imem_rvalid in IDLE is ignored (protocol error, not pushed).
- out_valid = count != 0; out_instr/out_pc = head entry.

## Timing
- Reset (rst low, async): fetch_pc=RESET_PC, count=0, state IDLE, imem_req=0 while in reset, out_valid=0, out_instr=0, out_pc=0 (head storage cleared).
- First request in first cycle after reset release with imem_addr=RESET_PC.
- Latency: response in cycle N appears at output in cycle N+1 (registered queue).
- Redirect in cycle N: no request in N; request to redirect_pc in N+1 if IDLE, else after DROP resolves.
- Full queue: imem_req held low; resumes the cycle after a pop frees a slot.
- Reset mid-WAIT: state cleared; any later stray rvalid is ignored in IDLE.

## Configuration
- IFETCH_BYPASS_EN defined: when count==0, state==WAIT and imem_rvalid (no redirect), out_valid/out_instr/out_pc are driven combinationally from imem_rdata/pend_pc; if out_ready, word is not pushed. Output latency 0 cycles.
- Undefined: outputs come only from the queue; latency 1 cycle.

## Structure
- Shared package mips_pkg: INSTR_W=32, ADDR_W=32, PC_STEP=4, fetch FSM state enum.
- Sub-module ifetch_fifo: DEPTH-entry synchronous FIFO of {instr,pc} with push, pop, flush, count; flush has priority over push.

## Test plan
- Reset release, imem_ready=1, rvalid one cycle after accept, out_ready=1 -> out_pc sequence 0x0,0x4,0x8 with matching words, one word per two cycles.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 words buffered, imem_req low, then drain in order 0x0..0xC.
- redirect to 0x40 while WAIT for 0x8 -> response for 0x8 discarded, next out_pc=0x40, queue emptied.
- redirect coincident with imem_rvalid -> word dropped, next request addr 0x40, no extra drop.
- redirect_pc=0x43 -> imem_addr=0x40; fetch_pc at 0xFFFF_FFFC wraps to 0x0.
- rst low during WAIT -> out_valid=0 immediately, restart at RESET_PC; with IFETCH_BYPASS_EN, first word visible in same cycle as rvalid.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: data widths, PC step and the
// fetch-stage FSM state encoding.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // IDLE: nothing outstanding; WAIT: one accepted request in flight;
    // DROP: in-flight response belongs to a squashed path and is discarded.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {instr, pc}.
// Flush has priority over push. Reset clears the storage so the head reads 0.
module ifetch_fifo import mips_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic [INSTR_W-1:0] o_head_instr,
    output logic [ADDR_W-1:0]  o_head_pc,
    output logic [CNT_W-1:0]   o_count
);

    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [ADDR_W-1:0]  r_pc    [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_instr[r_wr_ptr] <= i_instr;
                r_pc[r_wr_ptr]    <= i_pc;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head_instr = r_instr[r_rd_ptr];
    assign o_head_pc    = r_pc[r_rd_ptr];
    assign o_count      = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage with prefetch queue. One outstanding imem request,
// redirects flush the queue and squash the in-flight response.
// Optional build macro IFETCH_BYPASS_EN: forward a response straight to the
// output when the queue is empty (0-cycle latency); otherwise 1-cycle latency.
module ifetch_unit import mips_pkg::*; #(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_pend_pc;

    logic [CNT_W-1:0]   w_count;
    logic [INSTR_W-1:0] w_head_instr;
    logic [ADDR_W-1:0]  w_head_pc;
    logic               w_fifo_valid;
    logic               w_fire;
    logic               w_rsp;
    logic               w_byp;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    // In IDLE nothing is in flight, so count alone bounds the space check.
    // Gating with rst keeps the request low while reset is asserted.
    assign imem_req  = rst && !redirect && (r_state == StIdle) && (w_count < CNT_W'(DEPTH));
    assign imem_addr = r_fetch_pc;
    assign w_fire    = imem_req && imem_ready;

    // A live response: only WAIT responses are real; IDLE ones are stray.
    assign w_rsp = (r_state == StWait) && imem_rvalid && !redirect;

`ifdef IFETCH_BYPASS_EN
    assign w_byp = w_rsp && (w_count == '0);
`else
    assign w_byp = 1'b0;
`endif

    assign w_fifo_valid = (w_count != '0);
    assign w_push       = w_rsp && !(w_byp && out_ready);
    assign w_pop        = w_fifo_valid && out_ready;

    assign out_valid = w_fifo_valid || w_byp;
    assign out_instr = w_byp ? imem_rdata : w_head_instr;
    assign out_pc    = w_byp ? r_pend_pc  : w_head_pc;

    // Fetch PC, outstanding-request tracker and request FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            // A response landing with the redirect is the one being squashed,
            // so there is nothing left to drop.
            if (r_state != StIdle) begin
                r_state <= imem_rvalid ? StIdle : StDrop;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_fire) begin
                        r_pend_pc  <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + PC_STEP;
                        r_state    <= StWait;
                    end
                end
                StWait: if (imem_rvalid) r_state <= StIdle;
                StDrop: if (imem_rvalid) r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (redirect),
        .i_instr      (imem_rdata),
        .i_pc         (r_pend_pc),
        .o_head_instr (w_head_instr),
        .o_head_pc    (w_head_pc),
        .o_count      (w_count)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit (DEPTH=4, RESET_PC=0). The bench plays the
// instruction memory by hand; each word is a fixed function of its address.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    ifetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs respond to freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_rvalid = 1'b0;
        redirect = 1'b0;
        settle();
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);

        // ---- Streaming with out_ready=1: one word per two cycles ----
        do_reset();
        imem_ready = 1'b1;
        out_ready = 1'b1;
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("t1_req", imem_req, 1);
            chk("t1_addr", imem_addr, 32'(4 * k));
            step();
            imem_rvalid = 1'b1;
            imem_rdata = word(32'(4 * k));
            settle();
            chk("t1_req_wait", imem_req, 0);
`ifdef IFETCH_BYPASS_EN
            chk("t1_byp_valid", out_valid, 1);
            chk("t1_byp_pc", out_pc, 32'(4 * k));
            chk("t1_byp_instr", out_instr, word(32'(4 * k)));
`else
            chk("t1_valid_lat", out_valid, 0);
`endif
            step();
            imem_rvalid = 1'b0;
            settle();
`ifdef IFETCH_BYPASS_EN
            chk("t1_byp_nopush", out_valid, 0);
`else
            chk("t1_valid", out_valid, 1);
            chk("t1_pc", out_pc, 32'(4 * k));
            chk("t1_instr", out_instr, word(32'(4 * k)));
`endif
        end

        // ---- Back-pressure: queue fills to DEPTH, then drains in order ----
        do_reset();
        imem_ready = 1'b1;
        out_ready = 1'b0;
        settle();
        for (int k = 0; k < 4; k++) begin
            chk("t2_req", imem_req, 1);
            chk("t2_addr", imem_addr, 32'(4 * k));
            step();
            imem_rvalid = 1'b1;
            imem_rdata = word(32'(4 * k));
            settle();
            step();
            imem_rvalid = 1'b0;
            settle();
        end
        for (int k = 0; k < 4; k++) begin
            chk("t2_full_req", imem_req, 0);
            chk("t2_full_head", out_pc, 32'h0);
            step();
        end
        out_ready = 1'b1;
        imem_ready = 1'b0;
        settle();
        chk("t2_full_still", imem_req, 0);
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_valid", out_valid, 1);
            chk("t2_drain_pc", out_pc, 32'(4 * k));
            chk("t2_drain_instr", out_instr, word(32'(4 * k)));
            step();
            settle();
            if (k == 0) begin
                chk("t2_resume_req", imem_req, 1);
                chk("t2_resume_addr", imem_addr, 32'h10);
            end
        end
        chk("t2_empty", out_valid, 0);

        // ---- Redirect while WAIT for 0x8 ----
        do_reset();
        imem_ready = 1'b1;
        out_ready = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) begin
            step();
            imem_rvalid = 1'b1;
            imem_rdata = word(32'(4 * k));
            settle();
            step();
            imem_rvalid = 1'b0;
            settle();
        end
        chk("t3_addr8", imem_addr, 32'h8);
        chk("t3_two_queued", out_pc, 32'h0);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        settle();
        chk("t3_req_redir", imem_req, 0);
        step();
        redirect = 1'b0;
        settle();
        chk("t3_flushed", out_valid, 0);
        chk("t3_drop_req", imem_req, 0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata = word(32'h8);
        settle();
        chk("t3_drop_req2", imem_req, 0);
        step();
        imem_rvalid = 1'b0;
        settle();
        chk("t3_discarded", out_valid, 0);
        chk("t3_req40", imem_req, 1);
        chk("t3_addr40", imem_addr, 32'h40);
        step();
        imem_rvalid = 1'b1;
        imem_rdata = word(32'h40);
        settle();
        step();
        imem_rvalid = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("t3_valid40", out_valid, 1);
        chk("t3_pc40", out_pc, 32'h40);
        chk("t3_instr40", out_instr, word(32'h40));
        chk("t3_addr44", imem_addr, 32'h44);

        // ---- Redirect coincident with rvalid, misaligned target ----
        step();
        imem_rvalid = 1'b1;
        imem_rdata = word(32'h44);
        redirect = 1'b1;
        redirect_pc = 32'h43;
        settle();
        chk("t4_req_redir", imem_req, 0);
        step();
        imem_rvalid = 1'b0;
        redirect = 1'b0;
        settle();
        chk("t4_dropped", out_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h40);
        step();
        imem_rvalid = 1'b1;
        imem_rdata = word(32'h40);
        out_ready = 1'b0;
        settle();
        step();
        imem_rvalid = 1'b0;
        out_ready = 1'b1;
        imem_ready = 1'b0;
        settle();
        chk("t4_pc40", out_pc, 32'h40);
        chk("t4_addr44", imem_addr, 32'h44);

        // ---- Wrap of fetch_pc at 0xFFFF_FFFC ----
        step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        settle();
        chk("t5_req_redir", imem_req, 0);
        step();
        redirect = 1'b0;
        imem_ready = 1'b1;
        settle();
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        imem_rvalid = 1'b1;
        imem_rdata = word(32'hFFFF_FFFC);
        out_ready = 1'b0;
        settle();
        step();
        imem_rvalid = 1'b0;
        settle();
        chk("t5_pc_top", out_pc, 32'hFFFF_FFFC);
        chk("t5_instr_top", out_instr, word(32'hFFFF_FFFC));
        chk("t5_wrap_req", imem_req, 1);
        chk("t5_wrap_addr", imem_addr, 32'h0);

        // ---- Reset asserted mid-WAIT with a queued word ----
        step();
        settle();
        chk("t6_pre_valid", out_valid, 1);
        rst = 1'b0;
        settle();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_pc", out_pc, 0);
        chk("t6_rst_instr", out_instr, 0);
        chk("t6_rst_req", imem_req, 0);
        step();
        step();
        rst = 1'b1;
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = word(32'h0);
        settle();
        chk("t6_restart_addr", imem_addr, 32'h0);
        step();
        imem_rvalid = 1'b0;
        settle();
        chk("t6_stray_ignored", out_valid, 0);
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
